// File: rtl/seven_segment_decoder.sv
// Seven-segment bus decoder: synchronises an active-low segment bus, waits for it to settle,
// and reports each newly settled pattern once as a hex digit, a blank, or an error.
module seven_segment_decoder #(
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] hex_out,
    output logic       hex_valid,
    output logic       seg_blank,
    output logic       seg_err,
    output logic       locked
);

    localparam logic [6:0]       SEG_OFF = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        KIND_DIGIT,
        KIND_BLANK,
        KIND_ERR
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [3:0] digit;
    } decode_t;

    // Exact match on {g,f,e,d,c,b,a}; anything outside the table is an error.
    function automatic decode_t decode(input logic [6:0] seg);
        decode_t d;
        d.kind  = KIND_DIGIT;
        d.digit = 4'h0;
        case (seg)
            7'b1000000: d.digit = 4'h0;
            7'b1111001: d.digit = 4'h1;
            7'b0100100: d.digit = 4'h2;
            7'b0110000: d.digit = 4'h3;
            7'b0011001: d.digit = 4'h4;
            7'b0010010: d.digit = 4'h5;
            7'b0000010: d.digit = 4'h6;
            7'b1111000: d.digit = 4'h7;
            7'b0000000: d.digit = 4'h8;
            7'b0011000: d.digit = 4'h9;
            7'b0001000: d.digit = 4'hA;
            7'b0000011: d.digit = 4'hB;
            7'b1000110: d.digit = 4'hC;
            7'b0100001: d.digit = 4'hD;
            7'b0000110: d.digit = 4'hE;
            7'b0001110: d.digit = 4'hF;
            7'b1111111: d.kind  = KIND_BLANK;
            default:    d.kind  = KIND_ERR;
        endcase
        return d;
    endfunction

    logic [6:0]       s1;
    logic [6:0]       seg_s;
    logic [6:0]       cand;
    logic [6:0]       cand_next;
    logic [6:0]       last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             new_cand;
    logic             fire;
    decode_t          dec;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        new_cand  = (seg_s != cand);
        if (new_cand) begin
            cand_next = seg_s;
            cnt_next  = CNT_W'(1);
        end else if (cnt < CNT_MAX) begin
            cnt_next = cnt + CNT_W'(1);
        end
        // Report only on the edge that newly reaches the threshold, and only for a changed pattern.
        fire = (cnt_next == CNT_MAX) && (new_cand || (cnt != CNT_MAX)) && (cand_next != last);
        dec  = decode(cand_next);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= SEG_OFF;
            seg_s     <= SEG_OFF;
            cand      <= SEG_OFF;
            last      <= SEG_OFF;
            cnt       <= CNT_MAX;
            hex_out   <= 4'h0;
            hex_valid <= 1'b0;
            seg_blank <= 1'b0;
            seg_err   <= 1'b0;
            locked    <= 1'b1;
        end else begin
            s1        <= seg_in;
            seg_s     <= s1;
            cand      <= cand_next;
            cnt       <= cnt_next;
            locked    <= (cnt_next == CNT_MAX);
            hex_valid <= 1'b0;
            seg_blank <= 1'b0;
            seg_err   <= 1'b0;
            if (fire) begin
                last <= cand_next;
                case (dec.kind)
                    KIND_DIGIT: begin
                        hex_valid <= 1'b1;
                        hex_out   <= dec.digit;
                    end
                    KIND_BLANK: seg_blank <= 1'b1;
                    default:    seg_err   <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder at the default STABLE_CYCLES=4.
module tb_seven_segment_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic [3:0] hex_out;
    logic       hex_valid;
    logic       seg_blank;
    logic       seg_err;
    logic       locked;

    seven_segment_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .hex_out   (hex_out),
        .hex_valid (hex_valid),
        .seg_blank (seg_blank),
        .seg_err   (seg_err),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int errors = 0;
    int checks = 0;
    int n_valid, n_blank, n_err, n_multi;
    logic [3:0] vq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_blank = 0;
        n_err   = 0;
        vq.delete();
    endtask

    // Advance one clock and sample outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hex_valid) begin
            n_valid++;
            vq.push_back(hex_out);
        end
        if (seg_blank) n_blank++;
        if (seg_err)   n_err++;
        if (int'(hex_valid) + int'(seg_blank) + int'(seg_err) > 1) n_multi++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        n_multi = 0;
        clear_counts();

        // 1: reset then blank bus
        #12;
        check("rst_locked", 32'(locked), 32'd1);
        check("rst_hex", 32'(hex_out), 32'd0);
        check("rst_pulses", 32'(hex_valid | seg_blank | seg_err), 32'd0);
        rst_n = 1'b1;
        run(20);
        check("t1_pulses", 32'(n_valid + n_blank + n_err), 32'd0);
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_hex", 32'(hex_out), 32'd0);

        // 2: digit 3, latency of 6 edges, single one-cycle pulse
        clear_counts();
        seg_in = 7'b0110000;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("t2_valid_e%0d", e), 32'(hex_valid), 32'(e == 6));
            if (e == 6) check("t2_hex", 32'(hex_out), 32'h3);
        end
        clear_counts();
        run(50);
        check("t2_quiet", 32'(n_valid + n_blank + n_err), 32'd0);
        check("t2_locked", 32'(locked), 32'd1);

        // 3: sweep the whole table
        clear_counts();
        for (int d = 0; d < 16; d++) begin
            seg_in = TBL[d];
            run(10);
        end
        check("t3_nvalid", 32'(n_valid), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t3_order%0d", i), (i < vq.size()) ? 32'(vq[i]) : 32'hFFFF, 32'(i));
        check("t3_nerr", 32'(n_err), 32'd0);
        check("t3_nblank", 32'(n_blank), 32'd0);

        // 4: illegal code then blank
        seg_in = TBL[3];
        run(10);
        check("t4_hex3", 32'(hex_out), 32'h3);
        clear_counts();
        seg_in = 7'b1010101;
        run(10);
        check("t4_nerr", 32'(n_err), 32'd1);
        check("t4_nvalid", 32'(n_valid), 32'd0);
        check("t4_hex_kept", 32'(hex_out), 32'h3);
        clear_counts();
        seg_in = 7'h7F;
        run(10);
        check("t4_nblank", 32'(n_blank), 32'd1);
        check("t4_hex_kept2", 32'(hex_out), 32'h3);

        // 5: short and threshold-length glitches
        seg_in = TBL[5];
        run(10);
        check("t5_hex5", 32'(hex_out), 32'h5);
        clear_counts();
        seg_in = 7'b0000000;
        run(3);
        seg_in = TBL[5];
        run(20);
        check("t5_short_pulses", 32'(n_valid + n_blank + n_err), 32'd0);
        check("t5_short_hex", 32'(hex_out), 32'h5);
        check("t5_short_locked", 32'(locked), 32'd1);
        clear_counts();
        seg_in = 7'b0000000;
        run(4);
        seg_in = TBL[5];
        run(20);
        check("t5_long_nvalid", 32'(n_valid), 32'd2);
        check("t5_long_first", (vq.size() > 0) ? 32'(vq[0]) : 32'hFFFF, 32'h8);
        check("t5_long_second", (vq.size() > 1) ? 32'(vq[1]) : 32'hFFFF, 32'h5);

        // 6: reset in the middle of a pending candidate
        clear_counts();
        seg_in = TBL[9];
        run(3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_hex", 32'(hex_out), 32'd0);
        check("t6_rst_locked", 32'(locked), 32'd1);
        run(2);
        check("t6_rst_pulses", 32'(n_valid + n_blank + n_err), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("t6_valid_e%0d", e), 32'(hex_valid), 32'(e == 6));
            if (e == 6) check("t6_hex", 32'(hex_out), 32'h9);
        end
        run(20);
        check("t6_nvalid", 32'(n_valid), 32'd1);

        check("multi_pulse", 32'(n_multi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
